// File: rtl/multicycle_controller_pkg.sv
// riscv_mc_pkg: shared types and encodings for the multicycle RV32I controller.
// Holds the FSM state enum, opcodes, mux-select / ALUOp encodings and the
// per-state Moore control word.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALR_LINK,
    S_ILLEGAL
  } statetype_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // In FETCH, ir_write/pc_update mean "fetch in progress"; the FSM qualifies
  // them with MemReady at its outputs.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t moore_ctrl(statetype_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT;
                         c.ir_write = 1'b1; c.pc_update = 1'b1; end
      S_DECODE:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      S_MEMADR:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; end
      S_MEMREAD:   begin c.result_src = RES_ALUOUT; c.adr_src = 1'b1; end
      S_MEMWB:     begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_MEMWRITE:  begin c.result_src = RES_ALUOUT; c.adr_src = 1'b1;
                         c.mem_write = 1'b1; end
      S_EXECUTER:  begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2;
                         c.alu_op = ALUOP_FUNCT; end
      S_EXECUTEI:  begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM;
                         c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:     begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_BEQ:       begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2;
                         c.alu_op = ALUOP_SUB; c.result_src = RES_ALUOUT;
                         c.branch = 1'b1; end
      S_JAL:       begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                         c.result_src = RES_ALUOUT; c.pc_update = 1'b1; end
      // PC <= rs1+imm first, link written a cycle later so rd == rs1 is safe
      S_JALR:      begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM;
                         c.result_src = RES_ALURESULT; c.pc_update = 1'b1; end
      S_JALR_LINK: begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                         c.result_src = RES_ALURESULT; c.reg_write = 1'b1; end
      S_ILLEGAL:   c.illegal = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// aludec: ALU decoder. ALUOp 00 add, 01 sub, 10 by funct3/funct7b5.
// Ports: opb5 (op[5]), funct3, funct7b5, ALUOp in; ALUControl out.
module aludec
  import riscv_mc_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default:
        case (funct3)
          // funct7b5 selects sub only for R-type; addi ignores it
          3'b000:  ALUControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
    endcase
  end

endmodule

// File: rtl/multicycle_controller_mainfsm.sv
// mainfsm: state register, next-state logic and registered Moore outputs.
// Ports: clk/reset, op and MemReady in; AdrSrc, MemWrite, IRWrite, RegWrite,
// ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Branch, PCUpdate, Illegal out.
// While reset is high the selects read as FETCH and every enable is 0.
module mainfsm
  import riscv_mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       PCUpdate,
  output logic       Illegal
);

  localparam ctrl_t FETCH_CTRL = moore_ctrl(S_FETCH);

  statetype_t state;
  ctrl_t      q, sel;

  function automatic statetype_t next_state(statetype_t s, logic [6:0] opc, logic mr);
    statetype_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = mr ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opc)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXECUTER;
          OP_I:         n = S_EXECUTEI;
          OP_BEQ:       n = S_BEQ;
          OP_JAL:       n = S_JAL;
          OP_JALR:      n = S_JALR;
          default:      n = S_ILLEGAL;
        endcase
      S_MEMADR:   n = opc[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  n = mr ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: n = mr ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI, S_JAL: n = S_ALUWB;
      S_JALR:     n = S_JALR_LINK;
      S_ILLEGAL:  n = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  // Outputs are registered from the next state, so q always matches state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      q     <= FETCH_CTRL;
    end else begin
      state <= next_state(state, op, MemReady);
      q     <= moore_ctrl(next_state(state, op, MemReady));
    end
  end

  assign sel = reset ? FETCH_CTRL : q;

  assign AdrSrc    = sel.adr_src;
  assign ResultSrc = sel.result_src;
  assign ALUSrcA   = sel.alu_src_a;
  assign ALUSrcB   = sel.alu_src_b;
  assign ALUOp     = sel.alu_op;

  // ir_write marks FETCH, where both IR and PC updates wait on MemReady.
  assign IRWrite  = ~reset & q.ir_write & MemReady;
  assign PCUpdate = ~reset & q.pc_update & (~q.ir_write | MemReady);
  assign MemWrite = ~reset & q.mem_write;
  assign RegWrite = ~reset & q.reg_write;
  assign Branch   = ~reset & q.branch;
  assign Illegal  = ~reset & q.illegal;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle RV32I datapath.
// Ports: clk, reset (sync, active-high), op/funct3/funct7b5 from IR, Zero,
// MemReady in; PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
// ALUSrcB, ImmSrc, RegWrite, ALUControl, Illegal out.
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  logic [1:0] alu_op;
  logic       branch, pc_update;

  mainfsm #(.ILLEGAL_HALT(ILLEGAL_HALT)) u_fsm (
    .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(alu_op), .Branch(branch),
    .PCUpdate(pc_update), .Illegal(Illegal)
  );

  aludec u_aludec (
    .opb5(op[5]), .funct3(funct3), .funct7b5(funct7b5),
    .ALUOp(alu_op), .ALUControl(ALUControl)
  );

  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: two controllers (ILLEGAL_HALT=1 and 0) share inputs.
// Each cycle the driver pushes the expected output word of both DUTs; the
// negedge monitor pops and compares.
module tb_multicycle_controller;

  typedef enum {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB,
                T_BEQ, T_JAL, T_JALR, T_JL, T_ILL} tst_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b1;

  logic h_pcw, h_adr, h_mw, h_irw, h_rw, h_ill;
  logic [1:0] h_rs, h_sa, h_sb, h_imm;
  logic [2:0] h_ac;
  logic n_pcw, n_adr, n_mw, n_irw, n_rw, n_ill;
  logic [1:0] n_rs, n_sa, n_sb, n_imm;
  logic [2:0] n_ac;

  int n_tests = 0, n_fail = 0;
  string tag_q[$];
  logic [16:0] eh_q[$], en_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) u_dut_halt (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(h_pcw), .AdrSrc(h_adr),
    .MemWrite(h_mw), .IRWrite(h_irw), .ResultSrc(h_rs), .ALUSrcA(h_sa),
    .ALUSrcB(h_sb), .ImmSrc(h_imm), .RegWrite(h_rw), .ALUControl(h_ac),
    .Illegal(h_ill));

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) u_dut_nop (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(n_pcw), .AdrSrc(n_adr),
    .MemWrite(n_mw), .IRWrite(n_irw), .ResultSrc(n_rs), .ALUSrcA(n_sa),
    .ALUSrcB(n_sb), .ImmSrc(n_imm), .RegWrite(n_rw), .ALUControl(n_ac),
    .Illegal(n_ill));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected output word {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,
  // ALUSrcB,ImmSrc,RegWrite,ALUControl,Illegal} from the documented state table.
  function automatic logic [16:0] expv(tst_t s, logic rst, logic [6:0] o,
                                       logic [2:0] f3, logic f7, logic z, logic mr);
    tst_t st;
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, aop, imm;
    logic [2:0] ac;
    st = rst ? T_F : s;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sb, aop} = '0;
    case (st)
      T_F:    begin sb = 2'b10; rs = 2'b10; irw = mr & ~rst; pcw = mr & ~rst; end
      T_D:    begin sa = 2'b01; sb = 2'b01; end
      T_MA:   begin sa = 2'b10; sb = 2'b01; end
      T_MR:   adr = 1'b1;
      T_MWB:  begin rs = 2'b01; rw = 1'b1; end
      T_MW:   begin adr = 1'b1; mw = 1'b1; end
      T_ER:   begin sa = 2'b10; aop = 2'b10; end
      T_EI:   begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      T_AWB:  rw = 1'b1;
      T_BEQ:  begin sa = 2'b10; aop = 2'b01; pcw = z; end
      T_JAL:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      T_JALR: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pcw = 1'b1; end
      T_JL:   begin sa = 2'b01; sb = 2'b10; rs = 2'b10; rw = 1'b1; end
      default: ill = 1'b1;
    endcase
    case (o)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (aop)
      2'b00: ac = 3'b000;
      2'b01: ac = 3'b001;
      default:
        case (f3)
          3'b000:  ac = (o[5] & f7) ? 3'b001 : 3'b000;
          3'b010:  ac = 3'b101;
          3'b110:  ac = 3'b011;
          3'b111:  ac = 3'b010;
          default: ac = 3'b000;
        endcase
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, ac, ill};
  endfunction

  task automatic cyc(string tag, tst_t sh, tst_t sn, logic r, logic mr, logic z,
                     logic [6:0] o, logic [2:0] f3, logic f7);
    @(posedge clk);
    #1;
    reset = r; MemReady = mr; Zero = z; op = o; funct3 = f3; funct7b5 = f7;
    tag_q.push_back(tag);
    eh_q.push_back(expv(sh, r, o, f3, f7, z, mr));
    en_q.push_back(expv(sn, r, o, f3, f7, z, mr));
  endtask

  // One full instruction; MemReady/Zero are random wherever they must not matter.
  task automatic instr(string tag, logic [6:0] o, logic [2:0] f3, logic f7,
                       logic z, int fstall, int mstall);
    for (int i = 0; i < fstall; i++) cyc({tag, "/fwait"}, T_F, T_F, 0, 0, $urandom_range(0, 1), o, f3, f7);
    cyc({tag, "/fetch"}, T_F, T_F, 0, 1, $urandom_range(0, 1), o, f3, f7);
    cyc({tag, "/decode"}, T_D, T_D, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
    case (o)
      7'b0000011: begin
        cyc({tag, "/memadr"}, T_MA, T_MA, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
        for (int i = 0; i < mstall; i++) cyc({tag, "/rdwait"}, T_MR, T_MR, 0, 0, $urandom_range(0, 1), o, f3, f7);
        cyc({tag, "/memread"}, T_MR, T_MR, 0, 1, $urandom_range(0, 1), o, f3, f7);
        cyc({tag, "/memwb"}, T_MWB, T_MWB, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
      end
      7'b0100011: begin
        cyc({tag, "/memadr"}, T_MA, T_MA, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
        for (int i = 0; i < mstall; i++) cyc({tag, "/wrwait"}, T_MW, T_MW, 0, 0, $urandom_range(0, 1), o, f3, f7);
        cyc({tag, "/memwrite"}, T_MW, T_MW, 0, 1, $urandom_range(0, 1), o, f3, f7);
      end
      7'b0110011, 7'b0010011: begin
        if (o[5]) cyc({tag, "/execr"}, T_ER, T_ER, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
        else      cyc({tag, "/execi"}, T_EI, T_EI, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
        cyc({tag, "/aluwb"}, T_AWB, T_AWB, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
      end
      7'b1100011: cyc({tag, "/beq"}, T_BEQ, T_BEQ, 0, $urandom_range(0, 1), z, o, f3, f7);
      7'b1101111: begin
        cyc({tag, "/jal"}, T_JAL, T_JAL, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
        cyc({tag, "/aluwb"}, T_AWB, T_AWB, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
      end
      default: begin
        cyc({tag, "/jalr"}, T_JALR, T_JALR, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
        cyc({tag, "/jlink"}, T_JL, T_JL, 0, $urandom_range(0, 1), $urandom_range(0, 1), o, f3, f7);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (eh_q.size() > 0) begin
      string t;
      t = tag_q.pop_front();
      chk({t, "/halt"}, 32'({h_pcw, h_adr, h_mw, h_irw, h_rs, h_sa, h_sb, h_imm, h_rw, h_ac, h_ill}), 32'(eh_q.pop_front()));
      chk({t, "/nop"},  32'({n_pcw, n_adr, n_mw, n_irw, n_rs, n_sa, n_sb, n_imm, n_rw, n_ac, n_ill}), 32'(en_q.pop_front()));
      chk({t, "/onehot_wr"}, 32'(h_mw & h_rw), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) cyc("reset", T_F, T_F, 1, 1, 1, 7'b0110011, 3'b000, 1'b0);
    instr("sub", 7'b0110011, 3'b000, 1'b1, 0, 0, 0);
    instr("lw", 7'b0000011, 3'b010, 1'b0, 0, 0, 2);
    instr("sw", 7'b0100011, 3'b010, 1'b0, 0, 1, 1);
    instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1, 0, 0);
    instr("beq_n", 7'b1100011, 3'b000, 1'b0, 0, 0, 0);
    instr("jalr", 7'b1100111, 3'b000, 1'b0, 0, 0, 0);
    instr("jal", 7'b1101111, 3'b000, 1'b0, 0, 2, 0);
    instr("andi", 7'b0010011, 3'b111, 1'b1, 0, 0, 0);
    instr("or", 7'b0110011, 3'b110, 1'b0, 0, 0, 0);
    instr("slti", 7'b0010011, 3'b010, 1'b0, 0, 0, 0);
    instr("addi", 7'b0010011, 3'b000, 1'b1, 0, 0, 0);
    instr("lw0", 7'b0000011, 3'b010, 1'b0, 0, 0, 0);
    instr("sw0", 7'b0100011, 3'b010, 1'b0, 0, 0, 0);
    // reset while a store is waiting: aborts with no write strobe
    cyc("abort/fetch", T_F, T_F, 0, 1, 0, 7'b0100011, 3'b010, 1'b0);
    cyc("abort/decode", T_D, T_D, 0, 1, 0, 7'b0100011, 3'b010, 1'b0);
    cyc("abort/memadr", T_MA, T_MA, 0, 0, 0, 7'b0100011, 3'b010, 1'b0);
    cyc("abort/rst", T_F, T_F, 1, 0, 0, 7'b0100011, 3'b010, 1'b0);
    instr("after_abort", 7'b0110011, 3'b000, 1'b0, 0, 0, 0);
    // unknown opcode: halt variant traps, nop variant pulses and refetches
    cyc("ill/fetch", T_F, T_F, 0, 1, 0, 7'b1111111, 3'b000, 1'b0);
    cyc("ill/decode", T_D, T_D, 0, 1, 0, 7'b1111111, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc("ill/trap", T_ILL, (i % 3 == 0) ? T_ILL : ((i % 3 == 1) ? T_F : T_D),
          0, 1, $urandom_range(0, 1), 7'b1111111, 3'b000, 1'b0);
    cyc("ill/rst", T_F, T_F, 1, 1, 0, 7'b1111111, 3'b000, 1'b0);
    instr("post_ill", 7'b1100111, 3'b000, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk("sb_drain", 32'(eh_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM control unit for the multicycle RV32I datapath: one shared memory, an instruction register (IR), OldPC/ALUOut/Data registers and a single ALU.
- Sequences lw, sw, R-type, I-type ALU, beq, jal and jalr over several cycles.
- Drives register enables and mux selects, and stalls on a memory-ready handshake.
- Reuses the existing ALU decoder for ALUControl.

Parameters:
- ILLEGAL_HALT, 1, 1: an unknown opcode traps in ILLEGAL until reset. 0: an unknown opcode returns to FETCH as a NOP and pulses Illegal for one cycle.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  OldPC/IR enable
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Illegal  out  1  unknown opcode detected

Behaviour:
- Reset: synchronous, active-high, clock clk.
  - While reset is high: PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0; selects show FETCH values.
  - The first edge with reset low sees state FETCH.
  - Reset mid-instruction aborts it and returns to FETCH with no write strobe.
- Mux selects and ALUOp are Moore outputs of state. Unlisted selects are 0; unlisted enables are 0.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is decoded combinationally from op in every state.
- ALUOp: 00 add, 01 sub, 10 by funct. aludec uses op[5], funct3 and funct7b5.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when MemReady=1. Next state is DECODE if MemReady, else stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 1100111 -> JALR
    - otherwise -> ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next MEMWB if MemReady, else stay.
  - MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. MemWrite is held for every waiting cycle. Next FETCH if MemReady, else stay.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next ALUWB.
  - JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1 (PC <= rs1+imm). Next JALR_LINK.
  - JALR_LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1 (rd <= OldPC+4). Next FETCH. This ordering is correct when rd == rs1, because rs1 is consumed before rd is written.
  - ILLEGAL: Illegal=1. With ILLEGAL_HALT=1, stay until reset. With ILLEGAL_HALT=0, go to FETCH after one cycle.
- Cycles per instruction with MemReady held at 1: lw 5, sw 4, R 4, I 4, beq 3, jal 4, jalr 4. Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- At most one of MemWrite or RegWrite is asserted in any cycle.

Decomposition:
- Package riscv_mc_pkg holds:
  - the state enum statetype_t
  - opcode localparams OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR
  - ALUOp, ResultSrc, ALUSrcA and ALUSrcB encodings
- Sub-module mainfsm contains the state register, next-state logic and Moore outputs. It emits ALUOp, Branch and PCUpdate.
- The top level instantiates mainfsm and aludec, forms PCWrite, and decodes ImmSrc.

Test Plan:
- Reset: hold reset for 3 cycles, then release with MemReady=1 and op=0110011 -> no enable is asserted during reset. State sequence is FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegWrite=1 only in cycle 4.
- lw with MemReady low: op=0000011, MemReady=0 for 2 cycles in MEMREAD -> the instruction takes 7 cycles; AdrSrc=1 throughout the wait; RegWrite=1 only in MEMWB with ResultSrc=01.
- sw with stall: op=0100011, MemReady=0 for 1 cycle in MEMWRITE -> MemWrite=1 for exactly 2 consecutive cycles; ImmSrc=01; RegWrite is never asserted.
- beq: op=1100011, Zero=1 -> PCWrite=1 in BEQ with ALUControl=001. Repeat with Zero=0 -> PCWrite=0; 3 cycles each.
- jalr: op=1100111 -> PCWrite=1 with ResultSrc=10 in JALR; RegWrite=1 in JALR_LINK with ALUSrcA=01, ALUSrcB=10.
- Illegal opcode op=1111111: with ILLEGAL_HALT=1, Illegal stays 1 and all enables stay 0 for 10 cycles until reset. With ILLEGAL_HALT=0, Illegal pulses for 1 cycle, then FETCH.
